// File: rtl/circle_set_pkg.sv
// circle_set_pkg: shared types for the circle set counter.
// Holds the set-operation mode codes, the scan FSM state codes and the
// helper that sizes the point counter.
package circle_set_pkg;

   // Set operation selected by the mode input (6 and 7 count nothing)
   typedef enum logic [2:0] {
      MODE_C0     = 3'd0,  // inside circle 0
      MODE_AND01  = 3'd1,  // inside circle 0 and circle 1
      MODE_XOR01  = 3'd2,  // inside exactly one of circle 0 / circle 1
      MODE_EXACT2 = 3'd3,  // inside exactly two circles
      MODE_UNION  = 3'd4,  // inside any circle
      MODE_ISECT  = 3'd5   // inside every circle
   } mode_e;

   // Scan controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Counter width able to hold GRID_N*GRID_N without wrapping
   function automatic int cnt_w(input int grid_n);
      return $clog2(grid_n * grid_n + 1);
   endfunction

endpackage

// File: rtl/circle_member.sv
// circle_member: combinational point-in-circle test.
// o_in is high when (px-cx)^2 + (py-cy)^2 <= r^2. Differences are taken
// signed at COORD_W+1 bits and every square/sum is carried at 2*COORD_W+2
// bits, so nothing is truncated for any coordinate or radius value.
module circle_member #(
   parameter int COORD_W = 4
) (
   input  logic [COORD_W-1:0] i_px,
   input  logic [COORD_W-1:0] i_py,
   input  logic [COORD_W-1:0] i_cx,
   input  logic [COORD_W-1:0] i_cy,
   input  logic [COORD_W-1:0] i_r,
   output logic               o_in
);

   localparam int DW = COORD_W + 1;
   localparam int SW = 2 * COORD_W + 2;

   logic signed [DW-1:0] w_dx;
   logic signed [DW-1:0] w_dy;
   logic signed [SW-1:0] w_dx_ext;
   logic signed [SW-1:0] w_dy_ext;
   logic        [SW-1:0] w_dx2;
   logic        [SW-1:0] w_dy2;
   logic        [SW-1:0] w_r_ext;
   logic        [SW-1:0] w_r2;
   logic        [SW-1:0] w_sum;

   assign w_dx     = $signed({1'b0, i_px}) - $signed({1'b0, i_cx});
   assign w_dy     = $signed({1'b0, i_py}) - $signed({1'b0, i_cy});
   assign w_dx_ext = {{(SW-DW){w_dx[DW-1]}}, w_dx};
   assign w_dy_ext = {{(SW-DW){w_dy[DW-1]}}, w_dy};

   // Squares of signed differences are non-negative; keep them unsigned
   assign w_dx2    = unsigned'(w_dx_ext * w_dx_ext);
   assign w_dy2    = unsigned'(w_dy_ext * w_dy_ext);
   assign w_r_ext  = {{(SW-COORD_W){1'b0}}, i_r};
   assign w_r2     = w_r_ext * w_r_ext;
   assign w_sum    = w_dx2 + w_dy2;

   assign o_in     = (w_sum <= w_r2);

endmodule

// File: rtl/circle_set_counter.sv
// circle_set_counter: counts grid points (x,y in 1..GRID_N) that satisfy a
// set operation over NUM_CIRC circles. One point is evaluated per clock in
// raster order (x fastest); valid pulses once with the final count.
// Optional macro SET_DIST_PIPE_EN registers the membership result one stage
// ahead of the accumulator, adding a single drain cycle to the scan.
module circle_set_counter
   import circle_set_pkg::*;
#(
   parameter  int COORD_W  = 4,
   parameter  int GRID_N   = 8,
   parameter  int NUM_CIRC = 3,
   localparam int CNT_W    = cnt_w(GRID_N)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic [NUM_CIRC*2*COORD_W-1:0]   central,
   input  logic [NUM_CIRC*COORD_W-1:0]     radius,
   input  logic [2:0]                      mode,
   output logic                            busy,
   output logic                            valid,
   output logic [CNT_W-1:0]                candidate
);

   localparam logic [1:0] IDLE = 2'(ST_IDLE);
   localparam logic [1:0] SCAN = 2'(ST_SCAN);
   localparam logic [1:0] DONE = 2'(ST_DONE);

   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
   localparam logic [COORD_W-1:0] C_MAX = COORD_W'(GRID_N);

   logic [1:0]                    r_state;
   logic [COORD_W-1:0]            r_x;
   logic [COORD_W-1:0]            r_y;
   logic [NUM_CIRC*2*COORD_W-1:0] r_cen;
   logic [NUM_CIRC*COORD_W-1:0]   r_rad;
   logic [2:0]                    r_mode;
   logic                          r_busy;
   logic                          r_valid;
   logic [CNT_W-1:0]              r_cand;

   logic [NUM_CIRC-1:0]           w_mem;
   logic [2:0]                    w_pop;
   logic                          w_hit;
   logic                          w_last;
   logic                          w_acc_hit;
   logic                          w_acc_vld;

   assign busy      = r_busy;
   assign valid     = r_valid;
   assign candidate = r_cand;

   assign w_last = (r_x == C_MAX) && (r_y == C_MAX);

   // One membership tester per circle; circle 0 sits in the input MSBs
   for (genvar gi = 0; gi < NUM_CIRC; gi++) begin : g_circ
      localparam int CB = (NUM_CIRC - 1 - gi) * 2 * COORD_W;
      localparam int RB = (NUM_CIRC - 1 - gi) * COORD_W;
      circle_member #(.COORD_W(COORD_W)) u_member (
         .i_px (r_x),
         .i_py (r_y),
         .i_cx (r_cen[CB+COORD_W +: COORD_W]),
         .i_cy (r_cen[CB +: COORD_W]),
         .i_r  (r_rad[RB +: COORD_W]),
         .o_in (w_mem[gi])
      );
   end

   // Number of circles containing the current point
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NUM_CIRC; i++) begin
         w_pop = w_pop + 3'(w_mem[i]);
      end
   end

   // Apply the latched set operation to the membership flags
   always_comb begin
      w_hit = 1'b0;
      case (r_mode)
         MODE_C0:     w_hit = w_mem[0];
         MODE_AND01:  w_hit = w_mem[0] & w_mem[1];
         MODE_XOR01:  w_hit = w_mem[0] ^ w_mem[1];
         MODE_EXACT2: w_hit = (w_pop == 3'd2);
         MODE_UNION:  w_hit = |w_mem;
         MODE_ISECT:  w_hit = &w_mem;
         default:     w_hit = 1'b0;
      endcase
   end

`ifdef SET_DIST_PIPE_EN
   logic r_pipe_hit;
   logic r_pipe_vld;
   logic r_drain;

   // Register the per-point decision; the accumulator consumes it a cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pipe_hit <= 1'b0;
         r_pipe_vld <= 1'b0;
      end else begin
         r_pipe_hit <= w_hit;
         r_pipe_vld <= (r_state == SCAN) && !r_drain;
      end
   end

   assign w_acc_hit = r_pipe_hit;
   assign w_acc_vld = r_pipe_vld;
`else
   assign w_acc_hit = w_hit;
   assign w_acc_vld = (r_state == SCAN);
`endif

   // Scan controller, raster counters, latched operands and point counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_x     <= C_ONE;
         r_y     <= C_ONE;
         r_cen   <= '0;
         r_rad   <= '0;
         r_mode  <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_cand  <= '0;
`ifdef SET_DIST_PIPE_EN
         r_drain <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (w_acc_vld && w_acc_hit) begin
            r_cand <= r_cand + CNT_W'(1);
         end
         case (r_state)
            IDLE: begin
               if (en) begin
                  r_cen   <= central;
                  r_rad   <= radius;
                  r_mode  <= mode;
                  r_cand  <= '0;
                  r_x     <= C_ONE;
                  r_y     <= C_ONE;
                  r_busy  <= 1'b1;
                  r_state <= SCAN;
`ifdef SET_DIST_PIPE_EN
                  r_drain <= 1'b0;
`endif
               end
            end
            SCAN: begin
`ifdef SET_DIST_PIPE_EN
               if (r_drain) begin
                  r_state <= DONE;
               end else if (w_last) begin
                  r_drain <= 1'b1;
               end
`else
               if (w_last) begin
                  r_state <= DONE;
               end
`endif
               if (r_x == C_MAX) begin
                  r_x <= C_ONE;
                  r_y <= (r_y == C_MAX) ? C_ONE : r_y + C_ONE;
               end else begin
                  r_x <= r_x + C_ONE;
               end
            end
            DONE: begin
               r_valid <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_circle_set_counter.sv
// tb_circle_set_counter: scoreboard bench. Each accepted start pushes the
// expected count and the cycle on which valid must appear; a monitor pops
// and compares whenever valid is seen.
module tb_circle_set_counter;

   localparam int COORD_W  = 4;
   localparam int GRID_N   = 8;
   localparam int NUM_CIRC = 3;
   localparam int CNT_W    = 7;
`ifdef SET_DIST_PIPE_EN
   localparam int LAT = GRID_N * GRID_N + 2;
`else
   localparam int LAT = GRID_N * GRID_N + 1;
`endif

   typedef struct {
      int     cnt;
      longint cyc;
   } exp_t;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          en = 1'b0;
   logic [NUM_CIRC*2*COORD_W-1:0] central = '0;
   logic [NUM_CIRC*COORD_W-1:0]   radius = '0;
   logic [2:0]                    mode = '0;
   logic                          busy;
   logic                          valid;
   logic [CNT_W-1:0]              candidate;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   exp_t   q[$];
   logic   prev_valid = 1'b0;
   int     last_exp = 0;

   circle_set_counter #(
      .COORD_W  (COORD_W),
      .GRID_N   (GRID_N),
      .NUM_CIRC (NUM_CIRC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .central   (central),
      .radius    (radius),
      .mode      (mode),
      .busy      (busy),
      .valid     (valid),
      .candidate (candidate)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: count grid points straight from the membership rule
   function automatic int model(input logic [23:0] cen, input logic [11:0] rad,
                                input int md);
      int n = 0;
      for (int y = 1; y <= GRID_N; y++) begin
         for (int x = 1; x <= GRID_N; x++) begin
            bit m[3];
            int k = 0;
            bit hit;
            for (int i = 0; i < 3; i++) begin
               int cx = int'(cen[(2-i)*8+4 +: 4]);
               int cy = int'(cen[(2-i)*8 +: 4]);
               int r  = int'(rad[(2-i)*4 +: 4]);
               m[i] = ((x-cx)*(x-cx) + (y-cy)*(y-cy)) <= r*r;
               k += int'(m[i]);
            end
            case (md)
               0: hit = m[0];
               1: hit = m[0] && m[1];
               2: hit = m[0] != m[1];
               3: hit = (k == 2);
               4: hit = (k > 0);
               5: hit = (k == 3);
               default: hit = 1'b0;
            endcase
            n += int'(hit);
         end
      end
      return n;
   endfunction

   // Monitor: compare on every valid, and check valid is a single pulse
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("candidate", candidate, e.cnt);
               chk("valid_cycle", cyc, e.cyc);
               chk("busy_with_valid", busy, 0);
            end
            if (prev_valid) chk("valid_pulse", valid, 0);
         end
         prev_valid <= valid;
      end else begin
         prev_valid <= 1'b0;
      end
   end

   // Caller is at a negedge; drive a start and record the accept edge
   task automatic start(input logic [23:0] cen, input logic [11:0] rad,
                        input logic [2:0] md, input int exp, input bit push);
      exp_t e;
      central = cen;
      radius  = rad;
      mode    = md;
      en      = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("cand_cleared", candidate, 0);
      if (push) begin
         e.cnt = exp;
         e.cyc = cyc + LAT;
         q.push_back(e);
         last_exp = exp;
      end
   endtask

   // Wait (bounded) until valid is seen at a negedge; optionally scramble inputs
   task automatic wait_done(input bit scramble);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (valid) begin
            en = 1'b0;
            return;
         end
         if (scramble) begin
            en      = 1'($urandom_range(0, 1));
            mode    = 3'($urandom);
            central = 24'($urandom);
            radius  = 12'($urandom);
         end
      end
      en = 1'b0;
      chk("valid_timeout", 0, 1);
   endtask

   function automatic logic [23:0] cen3(input int x0, y0, x1, y1, x2, y2);
      return {4'(x0), 4'(y0), 4'(x1), 4'(y1), 4'(x2), 4'(y2)};
   endfunction

   initial begin
      logic [23:0] c;
      logic [11:0] r;
      logic [2:0]  md;

      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_valid", valid, 0);
      chk("reset_cand", candidate, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single circle r=2 fully inside grid: 13 points
      start(cen3(4,4,1,1,1,1), {4'd2,4'd0,4'd0}, 3'd0, 13, 1);
      wait_done(0);
      // Held value after valid
      repeat (3) @(negedge clk);
      chk("cand_hold", candidate, last_exp);

      start(cen3(4,4,4,4,1,1), {4'd2,4'd2,4'd0}, 3'd1, 13, 1);
      wait_done(0);
      // Back-to-back: en in the IDLE cycle right after valid
      start(cen3(4,4,4,4,1,1), {4'd2,4'd2,4'd0}, 3'd2, 0, 1);
      wait_done(0);

      @(negedge clk);
      start(cen3(1,1,8,8,4,4), 12'd0, 3'd4, 3, 1);
      wait_done(0);
      start(cen3(1,1,8,8,4,4), 12'd0, 3'd3, 0, 1);
      wait_done(0);
      start(cen3(1,1,8,8,4,4), 12'd0, 3'd5, 0, 1);
      wait_done(0);
      start(cen3(1,1,8,8,4,4), 12'd0, 3'd7, 0, 1);
      wait_done(0);
      start(cen3(8,8,1,1,1,1), {4'd15,4'd0,4'd0}, 3'd0, 64, 1);
      wait_done(0);

      // Reset in the middle of a scan discards the run
      @(negedge clk);
      start(cen3(4,4,5,5,3,3), {4'd3,4'd3,4'd3}, 3'd4, 0, 0);
      repeat (29) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_cand", candidate, 0);
      rst = 1'b0;
      @(negedge clk);
      c = cen3(4,4,5,5,3,3);
      r = {4'd3,4'd3,4'd3};
      start(c, r, 3'd4, model(c, r, 4), 1);
      wait_done(0);

      // Inputs scrambled while busy: result follows the latched operands only
      @(negedge clk);
      c = cen3(3,5,6,4,5,7);
      r = {4'd3,4'd2,4'd4};
      start(c, r, 3'd3, model(c, r, 3), 1);
      wait_done(1);
      repeat (80) @(negedge clk);
      chk("no_second_run", busy, 0);

      // Randomized runs against the reference model
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         c  = 24'($urandom);
         r  = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
               4'($urandom_range(0, 6))};
         md = 3'($urandom);
         start(c, r, md, model(c, r, int'(md)), 1);
         wait_done(0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
